// File: rtl/lte_dw_dfe_iq_demux_if.sv
// I/Q demux bus: serial I/Q/pad words in, paired 32-bit samples out.
// master drives i_* and reads o_*; slave is the demux side.
interface lte_dw_dfe_iq_demux_if #(
  parameter int ANT_W = 2
);
  logic [1:0]       i_mod_sel;
  logic             i_fram;
  logic             i_xant;
  logic [15:0]      i_data;
  logic             o_vld;
  logic [31:0]      o_data;
  logic [ANT_W-1:0] o_ant;
  logic             o_sop;
  logic             o_fram;
  logic             o_err;

  modport master (
    output i_mod_sel, i_fram, i_xant, i_data,
    input  o_vld, o_data, o_ant, o_sop, o_fram, o_err
  );

  modport slave (
    input  i_mod_sel, i_fram, i_xant, i_data,
    output o_vld, o_data, o_ant, o_sop, o_fram, o_err
  );
endinterface

// File: rtl/lte_dw_dfe_iq_demux.sv
// Re-pairs a serial per-slot I/Q/pad word stream into {I,Q} samples
// tagged with antenna, slot and frame markers; checks xant alignment.
// Ports: sys_clk_491p52, sys_rst_491p52 (async, active high),
//   bus (slave): i_mod_sel/i_fram/i_xant/i_data in, o_* sample out.
module lte_dw_dfe_iq_demux #(
  parameter int SAMP_NUM = 8,
  parameter int ANT_NUM  = 2,
  parameter int ANT_W    = 2
) (
  input  logic                 sys_clk_491p52,
  input  logic                 sys_rst_491p52,
  lte_dw_dfe_iq_demux_if.slave bus
);

  localparam int PW = 5;
  localparam int IW = $clog2(SAMP_NUM);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_pos;
  logic [ANT_W-1:0] r_ant;
  logic             r_len32;
  logic             r_fpend;
  logic [15:0]      r_ibuf [SAMP_NUM];

  logic             r_vld;
  logic [31:0]      r_data;
  logic [ANT_W-1:0] r_oant;
  logic             r_sop;
  logic             r_fram;
  logic             r_err;

  logic [PW-1:0]    w_last;
  logic             w_at_last;
  logic             w_run_word;
  logic             w_align_err;
  logic             w_iphase;
  logic             w_qphase;
  logic             w_iwr;
  logic [IW-1:0]    w_iidx;
  logic [IW-1:0]    w_qidx;
  logic             w_len32_in;
  logic [ANT_W-1:0] w_ant_inc;

  logic             w_vld_nxt;
  logic [31:0]      w_data_nxt;
  logic             w_sop_nxt;
  logic             w_fram_nxt;
  logic             w_err_nxt;

  assign w_last     = r_len32 ? PW'(31) : PW'(15);
  assign w_at_last  = (r_pos == w_last);
  // The i_fram word itself is never alignment-checked.
  assign w_run_word = (r_state == S_RUN) && !bus.i_fram;
  assign w_align_err = w_run_word && (bus.i_xant != w_at_last);
  assign w_iphase   = (r_pos < PW'(SAMP_NUM));
  assign w_qphase   = (r_pos >= PW'(SAMP_NUM)) &&
                      (r_pos < PW'(2 * SAMP_NUM));
  assign w_iwr      = bus.i_fram || (w_run_word && w_iphase);
  assign w_iidx     = bus.i_fram ? '0 : IW'(r_pos);
  assign w_qidx     = IW'(r_pos - PW'(SAMP_NUM));
  assign w_len32_in = (bus.i_mod_sel == 2'd1) ||
                      (bus.i_mod_sel == 2'd2);
  assign w_ant_inc  = (r_ant == ANT_W'(ANT_NUM - 1)) ?
                      '0 : r_ant + 1'b1;

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_fram) begin
      w_state_nxt = S_RUN;
    end else if (w_align_err) begin
      w_state_nxt = S_WAIT;
    end
  end

  // A Q sample still goes out on the cycle an alignment error is seen.
  always_comb begin
    w_vld_nxt  = w_run_word && w_qphase;
    w_data_nxt = {r_ibuf[w_qidx], bus.i_data};
    w_sop_nxt  = w_vld_nxt && (r_pos == PW'(SAMP_NUM));
    w_fram_nxt = w_sop_nxt && r_fpend;
    w_err_nxt  = w_align_err;
  end

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      r_pos   <= '0;
      r_ant   <= '0;
      r_len32 <= 1'b0;
      r_fpend <= 1'b0;
    end else if (bus.i_fram) begin
      r_pos   <= PW'(1);
      r_ant   <= '0;
      r_len32 <= w_len32_in;
      r_fpend <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_pos <= w_at_last ? '0 : r_pos + 1'b1;
      if (w_at_last) begin
        r_ant <= w_ant_inc;
      end
      if (w_sop_nxt) begin
        r_fpend <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk_491p52) begin
    if (w_iwr) begin
      r_ibuf[w_iidx] <= bus.i_data;
    end
  end

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_oant <= '0;
      r_sop  <= 1'b0;
      r_fram <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_vld  <= w_vld_nxt;
      r_sop  <= w_sop_nxt;
      r_fram <= w_fram_nxt;
      r_err  <= w_err_nxt;
      if (w_vld_nxt) begin
        r_data <= w_data_nxt;
        r_oant <= r_ant;
      end
    end
  end

  assign bus.o_vld  = r_vld;
  assign bus.o_data = r_data;
  assign bus.o_ant  = r_oant;
  assign bus.o_sop  = r_sop;
  assign bus.o_fram = r_fram;
  assign bus.o_err  = r_err;

endmodule
